// File: rtl/pbvi_backup_argmax.sv
// Sequential argmax over per-action candidate alpha vectors for every belief point.
// One action is scored per EVAL cycle; best value, alpha vector and action index are kept in registers.
//
// state | meaning
// IDLE  | waiting for start; results from the last backup are held
// EVAL  | scoring action act_cnt for all points, updating the running best
// DONE  | one-cycle done pulse; results valid
module pbvi_backup_argmax #(
    parameter int NUM_POINTS  = 16,
    parameter int NUM_STATES  = 2,
    parameter int NUM_ACTIONS = 3,
    parameter int DATA_W      = 16,
    parameter int ACT_W       = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1,
    parameter int VAL_W       = 2*DATA_W + ((NUM_STATES > 1) ? $clog2(NUM_STATES) : 1)
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic                                                         start,
    input  logic [NUM_ACTIONS-1:0][NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0] gamma_action_belief,
    input  logic [NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0]            point_belief,
    output logic                                                         busy,
    output logic                                                         done,
    output logic [NUM_POINTS-1:0][ACT_W-1:0]                             point_action,
    output logic [NUM_POINTS-1:0][NUM_STATES-1:0][DATA_W-1:0]            alpha,
    output logic [NUM_POINTS-1:0][VAL_W-1:0]                             max_val
);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    localparam logic [ACT_W-1:0] LAST_ACT = ACT_W'(NUM_ACTIONS - 1);

    state_t                          state, state_nxt;
    logic [ACT_W-1:0]                act_cnt, act_cnt_nxt;
    logic                            upd_en;
    logic [NUM_POINTS-1:0][VAL_W-1:0] val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            act_cnt <= '0;
        end else begin
            state   <= state_nxt;
            act_cnt <= act_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        act_cnt_nxt = act_cnt;
        upd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = EVAL;
                    act_cnt_nxt = '0;
                end
            end
            EVAL: begin
                upd_en = 1'b1;
                if (act_cnt == LAST_ACT) begin
                    state_nxt   = DONE;
                    act_cnt_nxt = '0;
                end else begin
                    act_cnt_nxt = act_cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Flags decode straight from the state register, so start never reaches them combinationally.
    assign busy = (state == EVAL) || (state == DONE);
    assign done = (state == DONE);

    always_comb begin
        val = '0;
        for (int i = 0; i < NUM_POINTS; i++) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                val[i] = val[i] + VAL_W'(point_belief[i][s]) * VAL_W'(gamma_action_belief[act_cnt][i][s]);
            end
        end
    end

    // Strict compare: on a tie the earlier (lower) action stays the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            point_action <= '0;
            alpha        <= '0;
            max_val      <= '0;
        end else if (upd_en) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                if ((act_cnt == '0) || (val[i] > max_val[i])) begin
                    max_val[i]      <= val[i];
                    alpha[i]        <= gamma_action_belief[act_cnt][i];
                    point_action[i] <= act_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_pbvi_backup_argmax.sv
// Directed-vector and random-regression bench for pbvi_backup_argmax (2 points, 2 states, 3 actions).
module tb_pbvi_backup_argmax;

    localparam int NP = 2;
    localparam int NS = 2;
    localparam int NA = 3;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int VW = 33;

    typedef struct {
        logic [NA-1:0][NP-1:0][NS-1:0][DW-1:0] g;
        logic [NP-1:0][NS-1:0][DW-1:0]         b;
        logic [NP-1:0][AW-1:0]                 exp_act;
        logic [NP-1:0][NS-1:0][DW-1:0]         exp_alpha;
        logic [NP-1:0][VW-1:0]                 exp_val;
    } vec_t;

    logic clk, rst, start;
    logic [NA-1:0][NP-1:0][NS-1:0][DW-1:0] gab;
    logic [NP-1:0][NS-1:0][DW-1:0]         pb;
    logic                                  busy, done;
    logic [NP-1:0][AW-1:0]                 point_action;
    logic [NP-1:0][NS-1:0][DW-1:0]         alpha;
    logic [NP-1:0][VW-1:0]                 max_val;

    int checks = 0;
    int errors = 0;
    vec_t tv [4];

    pbvi_backup_argmax #(
        .NUM_POINTS(NP), .NUM_STATES(NS), .NUM_ACTIONS(NA), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .gamma_action_belief(gab), .point_belief(pb),
        .busy(busy), .done(done),
        .point_action(point_action), .alpha(alpha), .max_val(max_val)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pr(input logic [15:0] s0, input logic [15:0] s1);
        return {s1, s0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic check_out(input vec_t v, input string tag);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s_act%0d", tag, p), 64'(point_action[p]), 64'(v.exp_act[p]));
            chk($sformatf("%s_alpha%0d", tag, p), 64'(alpha[p]), 64'(v.exp_alpha[p]));
            chk($sformatf("%s_val%0d", tag, p), 64'(max_val[p]), 64'(v.exp_val[p]));
        end
    endtask

    // Caller sits at a negedge; start is raised immediately so consecutive calls are back-to-back.
    task automatic run(input vec_t v, input bit poke);
        int done_at;
        done_at = -1;
        gab   = v.g;
        pb    = v.b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (done) begin
                done_at = c;
                chk("busy_in_done", 64'(busy), 64'd1);
                check_out(v, "res");
                break;
            end
            chk("busy_eval", 64'(busy), 64'd1);
            if (poke && c == 2) start = 1'b1;
            if (poke && c == 3) start = 1'b0;
            @(negedge clk);
        end
        chk("done_latency", 64'(done_at), 64'd4);
        if (done_at > 0) begin
            @(negedge clk);
            chk("busy_after_done", 64'(busy), 64'd0);
            chk("done_after_done", 64'(done), 64'd0);
            check_out(v, "hold");
        end
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t r;
        longint unsigned sum, best;
        r = v;
        for (int p = 0; p < NP; p++) begin
            best = 0;
            for (int a = 0; a < NA; a++) begin
                sum = 0;
                for (int s = 0; s < NS; s++)
                    sum += longint'(v.b[p][s]) * longint'(v.g[a][p][s]);
                if (a == 0 || sum > best) begin
                    best           = sum;
                    r.exp_act[p]   = AW'(a);
                    r.exp_alpha[p] = v.g[a][p];
                end
            end
            r.exp_val[p] = VW'(best);
        end
        return r;
    endfunction

    initial begin
        vec_t rv;

        // V0: action 2 only equals action 1 for p0, so action 1 keeps it
        tv[0].b[0] = pr(1, 2);
        tv[0].g[0][0] = pr(3, 3);  tv[0].g[1][0] = pr(10, 0); tv[0].g[2][0] = pr(0, 5);
        tv[0].exp_act[0] = 2'd1; tv[0].exp_alpha[0] = pr(10, 0); tv[0].exp_val[0] = 33'd10;
        tv[0].b[1] = pr(3, 1);
        tv[0].g[0][1] = pr(1, 1);  tv[0].g[1][1] = pr(0, 7);  tv[0].g[2][1] = pr(2, 0);
        tv[0].exp_act[1] = 2'd1; tv[0].exp_alpha[1] = pr(0, 7); tv[0].exp_val[1] = 33'd7;
        // V1: p0 last action strictly best; p1 tie between a0 and a1 keeps a0
        tv[1].b[0] = pr(1, 2);
        tv[1].g[0][0] = pr(3, 3);  tv[1].g[1][0] = pr(10, 0); tv[1].g[2][0] = pr(0, 6);
        tv[1].exp_act[0] = 2'd2; tv[1].exp_alpha[0] = pr(0, 6); tv[1].exp_val[0] = 33'd12;
        tv[1].b[1] = pr(1, 1);
        tv[1].g[0][1] = pr(2, 2);  tv[1].g[1][1] = pr(4, 0);  tv[1].g[2][1] = pr(1, 1);
        tv[1].exp_act[1] = 2'd0; tv[1].exp_alpha[1] = pr(2, 2); tv[1].exp_val[1] = 33'd4;
        // V2: full-width products; zero belief still loads a0 alpha
        tv[2].b[0] = pr(16'hFFFF, 16'hFFFF);
        for (int a = 0; a < NA; a++) tv[2].g[a][0] = pr(16'hFFFF, 16'hFFFF);
        tv[2].exp_act[0] = 2'd0; tv[2].exp_alpha[0] = pr(16'hFFFF, 16'hFFFF); tv[2].exp_val[0] = 33'h1_FFFC_0002;
        tv[2].b[1] = pr(0, 0);
        tv[2].g[0][1] = pr(5, 6);  tv[2].g[1][1] = pr(7, 8);  tv[2].g[2][1] = pr(9, 9);
        tv[2].exp_act[1] = 2'd0; tv[2].exp_alpha[1] = pr(5, 6); tv[2].exp_val[1] = 33'd0;
        // V3: p0 tie then later win; p1 win at a1 then tie at a2
        tv[3].b[0] = pr(2, 0);
        tv[3].g[0][0] = pr(1, 9);  tv[3].g[1][0] = pr(1, 0);  tv[3].g[2][0] = pr(3, 0);
        tv[3].exp_act[0] = 2'd2; tv[3].exp_alpha[0] = pr(3, 0); tv[3].exp_val[0] = 33'd6;
        tv[3].b[1] = pr(0, 1);
        tv[3].g[0][1] = pr(0, 5);  tv[3].g[1][1] = pr(9, 9);  tv[3].g[2][1] = pr(0, 9);
        tv[3].exp_act[1] = 2'd1; tv[3].exp_alpha[1] = pr(9, 9); tv[3].exp_val[1] = 33'd9;

        clk = 1'b0; rst = 1'b1; start = 1'b0; gab = '0; pb = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_act", 64'(point_action), 64'd0);
        chk("rst_alpha", 64'(alpha), 64'd0);
        chk("rst_val0", 64'(max_val[0]), 64'd0);
        chk("rst_val1", 64'(max_val[1]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run(tv[i], 1'b0);

        // start pulsed at E2 must be ignored; the next call checks back-to-back acceptance
        run(tv[0], 1'b1);
        run(tv[3], 1'b0);

        // reset after the first two actions were registered
        gab = tv[1].g; pb = tv[1].b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_act", 64'(point_action), 64'd0);
        chk("midrst_alpha", 64'(alpha), 64'd0);
        chk("midrst_val0", 64'(max_val[0]), 64'd0);
        chk("midrst_val1", 64'(max_val[1]), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_done", 64'({busy, done}), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        run(tv[1], 1'b0);

        for (int n = 0; n < 1000; n++) begin
            for (int a = 0; a < NA; a++)
                for (int p = 0; p < NP; p++)
                    for (int s = 0; s < NS; s++) begin
                        rv.g[a][p][s] = (n % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
                        if (a == 0) rv.b[p][s] = (n % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
                    end
            rv = model(rv);
            run(rv, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
